mem_ctrl: RTL

Memory controller sitting between the instruction cache / load-store buffer and the single byte-wide RAM port. It serialises 32-bit instruction fetches from the instruction cache and 1/2/4-byte loads and stores from the load-store buffer into per-byte RAM accesses, and returns assembled data with one-cycle done pulses. It provides fetch and load abort on branch mispredict, and holds back stores to the I/O region while the I/O buffer is full.

---
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Request, response and byte-wide RAM signals between the cache/LSB side and mem_ctrl.
// master drives requests and RAM read data; slave is the controller.
interface mem_ctrl_if;
    logic        rdy;
    logic        jump_wrong;
    logic        IC_inst_flag_in;
    logic [31:0] IC_PC_in;
    logic        IC_inst_flag_out;
    logic [31:0] IC_inst_out;
    logic        LSB_flag_in;
    logic        LSB_wr_in;
    logic [2:0]  LSB_len_in;
    logic [31:0] LSB_addr_in;
    logic [31:0] LSB_data_in;
    logic        LSB_flag_out;
    logic [31:0] LSB_data_out;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport master (
        output rdy, jump_wrong, IC_inst_flag_in, IC_PC_in,
        output LSB_flag_in, LSB_wr_in, LSB_len_in, LSB_addr_in, LSB_data_in,
        output mem_din, io_buffer_full,
        input  IC_inst_flag_out, IC_inst_out, LSB_flag_out, LSB_data_out,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  rdy, jump_wrong, IC_inst_flag_in, IC_PC_in,
        input  LSB_flag_in, LSB_wr_in, LSB_len_in, LSB_addr_in, LSB_data_in,
        input  mem_din, io_buffer_full,
        output IC_inst_flag_out, IC_inst_out, LSB_flag_out, LSB_data_out,
        output mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises fetches and 1/2/4-byte loads/stores onto a byte RAM port; reads done n+1 edges
// after accept, stores n edges (+1 per I/O-full hold); rdy=0 freezes everything.
module mem_ctrl (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        ic_flag_q, ic_flag_d;
    logic [31:0] ic_inst_q, ic_inst_d;
    logic        lsb_flag_q, lsb_flag_d;
    logic [31:0] lsb_data_q, lsb_data_d;

    logic [31:0] byte_addr;
    logic        io_hold;
    logic [1:0]  rd_sel;
    logic [31:0] rd_word;

    assign byte_addr = addr_q + {29'd0, step_q};
    assign io_hold   = bus.io_buffer_full && (byte_addr[17:16] == 2'b11);
    // RAM data lags the address by one edge, so the byte landing now belongs to step-2
    assign rd_sel    = step_q[1:0] - 2'd2;

    always_comb begin
        rd_word = asm_q;
        rd_word[{rd_sel, 3'b000} +: 8] = bus.mem_din;
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        len_d      = len_q;
        addr_d     = addr_q;
        data_d     = data_q;
        asm_d      = asm_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        ic_flag_d  = 1'b0;
        ic_inst_d  = ic_inst_q;
        lsb_flag_d = 1'b0;
        lsb_data_d = lsb_data_q;

        case (state_q)
            IDLE: begin
                if (bus.LSB_flag_in && (bus.LSB_wr_in || !bus.jump_wrong)) begin
                    addr_d  = bus.LSB_addr_in;
                    len_d   = bus.LSB_len_in;
                    data_d  = bus.LSB_data_in;
                    asm_d   = 32'd0;
                    mem_a_d = bus.LSB_addr_in;
                    if (bus.LSB_wr_in) begin
                        state_d = STORE;
                        if (bus.io_buffer_full && (bus.LSB_addr_in[17:16] == 2'b11)) begin
                            step_d = 3'd0;
                        end else begin
                            mem_dout_d = bus.LSB_data_in[7:0];
                            mem_wr_d   = 1'b1;
                            step_d     = 3'd1;
                        end
                    end else begin
                        state_d = LOAD;
                        step_d  = 3'd1;
                    end
                end else if (bus.IC_inst_flag_in && !bus.jump_wrong) begin
                    state_d = IFETCH;
                    addr_d  = bus.IC_PC_in;
                    len_d   = 3'd4;
                    asm_d   = 32'd0;
                    mem_a_d = bus.IC_PC_in;
                    step_d  = 3'd1;
                end
            end
            IFETCH, LOAD: begin
                if (bus.jump_wrong) begin
                    state_d = IDLE;
                    step_d  = 3'd0;
                    mem_a_d = 32'd0;
                end else begin
                    if (step_q < len_q) mem_a_d = byte_addr;
                    if (step_q >= 3'd2) asm_d = rd_word;
                    if (step_q == len_q + 3'd1) begin
                        state_d = IDLE;
                        step_d  = 3'd0;
                        if (state_q == IFETCH) begin
                            ic_flag_d = 1'b1;
                            ic_inst_d = rd_word;
                        end else begin
                            lsb_flag_d = 1'b1;
                            lsb_data_d = rd_word;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            STORE: begin
                if (step_q == len_q) begin
                    state_d    = IDLE;
                    step_d     = 3'd0;
                    mem_a_d    = 32'd0;
                    lsb_flag_d = 1'b1;
                end else begin
                    mem_a_d = byte_addr;
                    if (!io_hold) begin
                        mem_dout_d = data_q[{step_q[1:0], 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                        step_d     = step_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            len_q      <= 3'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            asm_q      <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            ic_flag_q  <= 1'b0;
            ic_inst_q  <= 32'd0;
            lsb_flag_q <= 1'b0;
            lsb_data_q <= 32'd0;
        end else if (bus.rdy) begin
            state_q    <= state_d;
            step_q     <= step_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            asm_q      <= asm_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            ic_flag_q  <= ic_flag_d;
            ic_inst_q  <= ic_inst_d;
            lsb_flag_q <= lsb_flag_d;
            lsb_data_q <= lsb_data_d;
        end
    end

    assign bus.mem_a            = mem_a_q;
    assign bus.mem_dout         = mem_dout_q;
    assign bus.mem_wr           = mem_wr_q;
    assign bus.IC_inst_flag_out = ic_flag_q;
    assign bus.IC_inst_out      = ic_inst_q;
    assign bus.LSB_flag_out     = lsb_flag_q;
    assign bus.LSB_data_out     = lsb_data_q;
endmodule
